// File: rtl/pst_pkg.sv
// ============================================================================
// Module : pst_pkg
// Brief  : Shared types and helpers for the predictive phase hierarchy.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int PHASE_W_MAX = 16;
    localparam int ETA_CAP     = 16;
    // Half-scale of the widest supported phase; narrower widths shift it down.
    localparam logic [PHASE_W_MAX-1:0] PHASE_INIT = 16'h8000;

    typedef struct packed {
        logic                   sign;
        logic [PHASE_W_MAX-1:0] mag;
    } diff_t;

    // Shortest circular distance actual-pred; exact half-turn reports sign 0.
    function automatic diff_t phase_diff(input logic [PHASE_W_MAX-1:0] actual,
                                         input logic [PHASE_W_MAX-1:0] pred,
                                         input int pw);
        logic [PHASE_W_MAX-1:0] mask;
        logic [PHASE_W_MAX-1:0] half;
        logic [PHASE_W_MAX-1:0] d;
        diff_t                  r;
        mask = PHASE_W_MAX'((32'd1 << pw) - 32'd1);
        half = PHASE_W_MAX'(32'd1 << (pw - 1));
        d    = (actual - pred) & mask;
        if (d < half) begin
            r.sign = 1'b1;
            r.mag  = d;
        end else begin
            r.sign = 1'b0;
            r.mag  = (mask - d) + 16'd1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pst_layer_update.sv
// ============================================================================
// Module : pst_layer_update
// Brief  : Combinational per-layer learning datapath (error, eta, new pred/weight).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pst_layer_update
    import pst_pkg::*;
#(
    parameter int PW          = 8,
    parameter int ETA_LTP     = 4,
    parameter int ETA_LTD     = 3,
    parameter int WINDOW      = 128,
    parameter int BOOST_SHIFT = 2
) (
    input  logic [PW-1:0] i_actual,
    input  logic [PW-1:0] i_pred,
    input  logic [7:0]    i_weight,
    input  logic [PW-1:0] i_upper_err,
    input  logic          i_boost_en,
    input  logic          i_frozen,
    output logic          o_err_sign,
    output logic [PW-1:0] o_err_mag,
    output logic [7:0]    o_boost,
    output logic [PW-1:0] o_new_pred,
    output logic [7:0]    o_new_weight
);

    diff_t         w_diff;
    logic [PW+7:0] w_boost_wide;
    logic [8:0]    w_eta_sum;
    logic [4:0]    w_eta;
    logic [PW+4:0] w_prod;
    logic [PW-1:0] w_step;
    logic [8:0]    w_wsum;
    logic          w_in_window;

    assign w_diff     = phase_diff(PHASE_W_MAX'(i_actual), PHASE_W_MAX'(i_pred), PW);
    assign o_err_sign = w_diff.sign;
    assign o_err_mag  = PW'(w_diff.mag);

    assign w_boost_wide = {8'd0, i_upper_err} >> BOOST_SHIFT;
    assign o_boost      = !i_boost_en ? 8'd0 :
                          (w_boost_wide > (PW+8)'(255)) ? 8'hFF : 8'(w_boost_wide);

    assign w_eta_sum = 9'(ETA_LTP) + {1'b0, o_boost};
    assign w_eta     = (w_eta_sum > 9'(ETA_CAP)) ? 5'(ETA_CAP) : 5'(w_eta_sum);

    // eta never exceeds 16, so the shifted product never exceeds the error.
    assign w_prod = {5'd0, o_err_mag} * (PW+5)'(w_eta);
    assign w_step = PW'(w_prod >> 4);

    assign w_in_window = ({1'b0, o_err_mag} < (PW+1)'(WINDOW));
    assign w_wsum      = {1'b0, i_weight} + 9'(ETA_LTP);

    always_comb begin
        o_new_pred   = i_pred;
        o_new_weight = i_weight;
        if (!i_frozen) begin
            if (w_in_window) begin
                o_new_pred   = o_err_sign ? (i_pred + w_step) : (i_pred - w_step);
                o_new_weight = w_wsum[8] ? 8'hFF : w_wsum[7:0];
            end else begin
                o_new_weight = (i_weight < 8'(ETA_LTD)) ? 8'd0 : (i_weight - 8'(ETA_LTD));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pst_hier_seq.sv
// ============================================================================
// Module : pst_hier_seq
// Brief  : Multi-layer predictive phase hierarchy, one shared update per clock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pst_hier_seq
    import pst_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int PW          = 8,
    parameter int W_INIT      = 128,
    parameter int ETA_LTP     = 4,
    parameter int ETA_LTD     = 3,
    parameter int WINDOW      = 128,
    parameter int BOOST_SHIFT = 2,
    parameter int LW          = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cycle_start,
    input  logic [PW-1:0]         phase_in,
    input  logic                  fired_in,
    input  logic [NUM_LAYERS-1:0] freeze_mask,
    input  logic [LW-1:0]         mon_sel,
    output logic [PW-1:0]         mon_pred,
    output logic [PW-1:0]         mon_err,
    output logic                  mon_sign,
    output logic [7:0]            mon_weight,
    output logic [7:0]            mon_boost,
    output logic [PW-1:0]         pred_top,
    output logic                  busy,
    output logic                  done,
    output logic                  err_valid,
    output logic                  overrun
);

    localparam logic [PW-1:0] c_phase_init = PW'(PHASE_INIT >> (PHASE_W_MAX - PW));
    localparam logic [LW-1:0] c_top        = LW'(NUM_LAYERS - 1);

    state_t                r_state;
    logic [LW-1:0]         r_k;
    logic [PW-1:0]         r_phase;
    logic                  r_fired;
    logic [NUM_LAYERS-1:0] r_freeze;
    logic                  r_busy, r_done, r_err_valid, r_overrun;

    logic [PW-1:0] r_pred   [NUM_LAYERS];
    logic [7:0]    r_weight [NUM_LAYERS];
    logic [PW-1:0] r_err    [NUM_LAYERS];
    logic          r_sign   [NUM_LAYERS];
    logic [7:0]    r_boost  [NUM_LAYERS];

    logic [LW-1:0] w_k_up, w_k_dn;
    logic          w_top, w_sel_ok;
    logic [PW-1:0] w_actual, w_err, w_new_pred;
    logic          w_sign;
    logic [7:0]    w_boost, w_new_weight;

    assign w_k_up   = r_k + LW'(1);
    assign w_k_dn   = r_k - LW'(1);
    assign w_top    = (r_k == c_top);
    // Layers above the bottom learn from the prediction just written below them.
    assign w_actual = (r_k == '0) ? r_phase : r_pred[w_k_dn];

    pst_layer_update #(
        .PW          (PW),
        .ETA_LTP     (ETA_LTP),
        .ETA_LTD     (ETA_LTD),
        .WINDOW      (WINDOW),
        .BOOST_SHIFT (BOOST_SHIFT)
    ) u_update (
        .i_actual     (w_actual),
        .i_pred       (r_pred[r_k]),
        .i_weight     (r_weight[r_k]),
        .i_upper_err  (r_err[w_k_up]),
        .i_boost_en   (!w_top && !r_freeze[w_k_up]),
        .i_frozen     (r_freeze[r_k]),
        .o_err_sign   (w_sign),
        .o_err_mag    (w_err),
        .o_boost      (w_boost),
        .o_new_pred   (w_new_pred),
        .o_new_weight (w_new_weight)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_phase     <= '0;
            r_fired     <= 1'b0;
            r_freeze    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_valid <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_pred[i]   <= c_phase_init;
                r_weight[i] <= 8'(W_INIT);
                r_err[i]    <= '0;
                r_sign[i]   <= 1'b0;
                r_boost[i]  <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (cycle_start && r_busy)
                r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (cycle_start) begin
                        r_phase  <= phase_in;
                        r_fired  <= fired_in;
                        r_freeze <= freeze_mask;
                        r_k      <= '0;
                        if (fired_in) begin
                            r_state <= UPDATE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state     <= FINISH;
                            r_err_valid <= 1'b0;
                        end
                    end
                end
                UPDATE: begin
                    r_pred[r_k]   <= w_new_pred;
                    r_weight[r_k] <= w_new_weight;
                    r_err[r_k]    <= w_err;
                    r_sign[r_k]   <= w_sign;
                    r_boost[r_k]  <= w_boost;
                    if (w_top)
                        r_state <= FINISH;
                    else
                        r_k <= w_k_up;
                end
                FINISH: begin
                    r_done      <= 1'b1;
                    r_err_valid <= r_fired;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_sel_ok   = ({1'b0, mon_sel} < (LW+1)'(NUM_LAYERS));
    assign mon_pred   = w_sel_ok ? r_pred[mon_sel]   : '0;
    assign mon_err    = w_sel_ok ? r_err[mon_sel]    : '0;
    assign mon_sign   = w_sel_ok ? r_sign[mon_sel]   : 1'b0;
    assign mon_weight = w_sel_ok ? r_weight[mon_sel] : '0;
    assign mon_boost  = w_sel_ok ? r_boost[mon_sel]  : '0;
    assign pred_top   = r_pred[NUM_LAYERS-1];
    assign busy       = r_busy;
    assign done       = r_done;
    assign err_valid  = r_err_valid;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_pst_hier_seq.sv
// ============================================================================
// Module : tb_pst_hier_seq
// Brief  : Self-checking bench: spec vectors, corner sequences, random vs model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pst_hier_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cycle_start = 1'b0;
    logic [7:0]   phase_in = '0;
    logic         fired_in = 1'b0;
    logic [N-1:0] freeze_mask = '0;
    logic [1:0]   mon_sel = '0;
    logic [7:0]   mon_pred, mon_err, mon_weight, mon_boost, pred_top;
    logic         mon_sign, busy, done, err_valid, overrun;

    int total = 0;
    int bad   = 0;

    // Reference state, indexed by layer.
    int mp[N], mw[N], me[N], ms[N], mb[N];
    int mev;

    pst_hier_seq dut (
        .clk(clk), .rst(rst), .cycle_start(cycle_start), .phase_in(phase_in),
        .fired_in(fired_in), .freeze_mask(freeze_mask), .mon_sel(mon_sel),
        .mon_pred(mon_pred), .mon_err(mon_err), .mon_sign(mon_sign),
        .mon_weight(mon_weight), .mon_boost(mon_boost), .pred_top(pred_top),
        .busy(busy), .done(done), .err_valid(err_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mp[k] = 128; mw[k] = 128; me[k] = 0; ms[k] = 0; mb[k] = 0;
        end
        mev = 0;
    endtask

    // Bottom-up walk of the learning rules on integers.
    task automatic model_seq(input int ph, input int f, input int mask);
        int act, d, mag, sgn, b, eta, step;
        mev = f;
        if (f == 0) return;
        act = ph;
        for (int k = 0; k < N; k++) begin
            d = (act - mp[k]) & 255;
            if (d < 128) begin sgn = 1; mag = d; end
            else begin sgn = 0; mag = 256 - d; end
            b = (k < N-1 && ((mask >> (k+1)) & 1) == 0) ? (me[k+1] >> 2) : 0;
            eta = (4 + b > 16) ? 16 : 4 + b;
            me[k] = mag; ms[k] = sgn; mb[k] = b;
            if (((mask >> k) & 1) == 0) begin
                if (mag < 128) begin
                    step = (mag * eta) / 16;
                    mp[k] = sgn ? (mp[k] + step) % 256 : (mp[k] - step + 256) % 256;
                    mw[k] = (mw[k] + 4 > 255) ? 255 : mw[k] + 4;
                end else begin
                    mw[k] = (mw[k] < 3) ? 0 : mw[k] - 3;
                end
            end
            act = mp[k];
        end
    endtask

    task automatic do_reset();
        cycle_start = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // lat = clocks from the strobe edge to the first clock with done high.
    task automatic run_seq(input int ph, input int f, input int mask, output int lat);
        phase_in = 8'(ph); fired_in = f[0]; freeze_mask = 4'(mask);
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        model_seq(ph, f, mask);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic check_layer(input int k, input string tag);
        mon_sel = 2'(k);
        #1;
        chk({tag, "_pred"},   int'(mon_pred),   mp[k]);
        chk({tag, "_err"},    int'(mon_err),    me[k]);
        chk({tag, "_sign"},   int'(mon_sign),   ms[k]);
        chk({tag, "_weight"}, int'(mon_weight), mw[k]);
        chk({tag, "_boost"},  int'(mon_boost),  mb[k]);
    endtask

    typedef struct {
        int phase; int fired; int mask; int sel;
        int e_pred; int e_err; int e_sign; int e_weight;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int lat, ndone, f, m;

        tbl[0] = '{160, 1, 0, 0, 136,  32, 1, 132};
        tbl[1] = '{160, 1, 0, 1, 130,   8, 1, 132};
        tbl[2] = '{ 10, 1, 0, 0,  99, 118, 0, 132};
        tbl[3] = '{ 10, 1, 0, 1, 121,  29, 0, 132};
        tbl[4] = '{  0, 1, 0, 0, 128, 128, 0, 125};
        tbl[5] = '{  0, 1, 0, 1, 128,   0, 1, 132};
        tbl[6] = '{160, 0, 0, 0, 128,   0, 0, 128};
        tbl[7] = '{160, 1, 1, 0, 128,  32, 1, 128};

        // Reset state of every layer
        do_reset();
        for (int k = 0; k < N; k++) begin
            mon_sel = 2'(k);
            #1;
            chk("rst_pred", int'(mon_pred), 128);
            chk("rst_weight", int'(mon_weight), 128);
        end
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_done", int'(done), 0);

        // Spec vectors, each from a fresh reset
        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_seq(tbl[i].phase, tbl[i].fired, tbl[i].mask, lat);
            chk("vec_latency", lat, tbl[i].fired ? N + 1 : 1);
            chk("vec_err_valid", int'(err_valid), tbl[i].fired);
            mon_sel = 2'(tbl[i].sel);
            #1;
            chk("vec_pred", int'(mon_pred), tbl[i].e_pred);
            chk("vec_err", int'(mon_err), tbl[i].e_err);
            chk("vec_sign", int'(mon_sign), tbl[i].e_sign);
            chk("vec_weight", int'(mon_weight), tbl[i].e_weight);
        end

        // Boost from the layer above, then freezing that layer
        do_reset();
        run_seq(160, 1, 0, lat);
        run_seq(160, 1, 0, lat);
        mon_sel = 2'd0; #1;
        chk("boost_val", int'(mon_boost), 2);
        chk("boost_pred", int'(mon_pred), 145);
        run_seq(160, 1, 4'b0010, lat);
        mon_sel = 2'd0; #1;
        chk("frz_boost0", int'(mon_boost), 0);
        chk("frz_pred0", int'(mon_pred), 148);
        mon_sel = 2'd1; #1;
        chk("frz_pred1", int'(mon_pred), 133);
        chk("frz_weight1", int'(mon_weight), 136);
        chk("frz_err1", int'(mon_err), 15);

        // Weight saturation at 0 and at 255
        do_reset();
        mon_sel = 2'd0;
        for (int i = 1; i <= 44; i++) begin
            run_seq(0, 1, 0, lat);
            #1;
            if (i == 42) chk("wsat_lo_42", int'(mon_weight), 2);
            if (i == 43) chk("wsat_lo_43", int'(mon_weight), 0);
            if (i == 44) chk("wsat_lo_44", int'(mon_weight), 0);
        end
        do_reset();
        for (int i = 1; i <= 33; i++) begin
            run_seq(128, 1, 0, lat);
            #1;
            if (i == 31) chk("wsat_hi_31", int'(mon_weight), 252);
            if (i == 33) chk("wsat_hi_33", int'(mon_weight), 255);
        end

        // Strobe while busy: flagged, result unchanged
        do_reset();
        phase_in = 8'd160; fired_in = 1'b1; freeze_mask = '0;
        cycle_start = 1'b1; tick(); cycle_start = 1'b0;
        tick();
        cycle_start = 1'b1; phase_in = 8'd0; tick(); cycle_start = 1'b0;
        lat = 0;
        for (int i = 3; i <= 20; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        chk("ovr_latency", lat, N + 1);
        chk("ovr_flag", int'(overrun), 1);
        mon_sel = 2'd0; #1;
        chk("ovr_pred0", int'(mon_pred), 136);
        mon_sel = 2'd1; #1;
        chk("ovr_pred1", int'(mon_pred), 130);

        // Asynchronous reset in the middle of a sequence
        do_reset();
        phase_in = 8'd160; fired_in = 1'b1;
        cycle_start = 1'b1; tick(); cycle_start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        mon_sel = 2'd0; #1;
        chk("amid_pred0", int'(mon_pred), 128);
        chk("amid_weight0", int'(mon_weight), 128);
        chk("amid_busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("amid_no_done", ndone, 0);

        // Randomized sequences against the reference model
        do_reset();
        model_reset();
        for (int it = 0; it < 150; it++) begin
            f = ($urandom_range(3) != 0) ? 1 : 0;
            m = ($urandom_range(2) == 0) ? int'($urandom_range(15)) : 0;
            run_seq(int'($urandom_range(255)), f, m, lat);
            chk("rnd_latency", lat, f ? N + 1 : 1);
            chk("rnd_err_valid", int'(err_valid), mev);
            chk("rnd_pred_top", int'(pred_top), mp[N-1]);
            for (int k = 0; k < N; k++) check_layer(k, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
